// File: rtl/pc_fetch16.sv
// pc_fetch16: program counter with a valid/ready fetch handshake.
// Holds the current fetch address, advances by one on an accepted fetch
// when inc_en is high, and redirects on load (to `in`) or clr (to
// RESET_ADDR). A registered flush pulse marks each redirect.
// Optional feature macro: PC_WRAP_FLAG_EN adds a sticky `wrapped` output
// that is set when an increment rolls the counter from all-ones to zero.
module pc_fetch16 #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             clr,
  input  logic             inc_en,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] out,
  output logic             flush
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic             wrapped
`endif
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic             redirect;
  logic             fire;
  logic             advance;

  assign fire     = fetch_valid & fetch_ready;
  assign redirect = clr | load;
  assign advance  = ~redirect & fire & inc_en;

  // State register: BOOT after reset, RUN from the first clocked edge onward
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: BOOT always leaves on the first edge, RUN is absorbing
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Output decode: fetch_valid depends only on registered state
  always_comb begin
    fetch_valid = 1'b0;
    case (state)
      BOOT:    fetch_valid = 1'b0;
      RUN:     fetch_valid = 1'b1;
      default: fetch_valid = 1'b0;
    endcase
  end

  // Next-pc selection: clr over load over sequential advance over hold
  always_comb begin
    pc_nxt = out;
    if (clr) begin
      pc_nxt = RESET_ADDR;
    end else if (load) begin
      pc_nxt = in;
    end else if (advance) begin
      pc_nxt = out + WIDTH'(1);
    end
  end

  // Program counter and flush pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= RESET_ADDR;
      flush <= 1'b0;
    end else begin
      out   <= pc_nxt;
      flush <= redirect;
    end
  end

`ifdef PC_WRAP_FLAG_EN
  // Sticky wrap flag: set on all-ones increment, cleared only by clr or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrapped <= 1'b0;
    end else if (clr) begin
      wrapped <= 1'b0;
    end else if (advance && (&out)) begin
      wrapped <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch16.sv
// Directed self-checking bench for pc_fetch16 (default WIDTH=16, RESET_ADDR=0).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_pc_fetch16;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_d;
  logic        load;
  logic        clr;
  logic        inc_en;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [15:0] out_q;
  logic        flush;
`ifdef PC_WRAP_FLAG_EN
  logic        wrapped;
`endif

  int checks   = 0;
  int failures = 0;

  pc_fetch16 #(.WIDTH(16), .RESET_ADDR(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in_d),
    .load        (load),
    .clr         (clr),
    .inc_en      (inc_en),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .out         (out_q),
    .flush       (flush)
`ifdef PC_WRAP_FLAG_EN
    ,
    .wrapped     (wrapped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_d = 16'h0000; load = 1'b0; clr = 1'b0;
    inc_en = 1'b1; fetch_ready = 1'b1;
    step();
    step();
    checks++;
    if (out_q !== 16'h0000 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
      $display("FAIL reset_state: out=%h valid=%b flush=%b required out=0000 valid=0 flush=0",
               out_q, fetch_valid, flush);
      failures++;
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || out_q !== 16'h0000) begin
      $display("FAIL boot_cycle: out=%h valid=%b required out=0000 valid=0", out_q, fetch_valid);
      failures++;
    end
    step();
    checks++;
    if (fetch_valid !== 1'b1 || out_q !== 16'h0000) begin
      $display("FAIL run_entry: out=%h valid=%b required out=0000 valid=1", out_q, fetch_valid);
      failures++;
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if (out_q !== 16'(i) || fetch_valid !== 1'b1 || flush !== 1'b0) begin
        $display("FAIL seq_advance[%0d]: out=%h valid=%b flush=%b required out=%h valid=1 flush=0",
                 i, out_q, fetch_valid, flush, 16'(i));
        failures++;
      end
    end
  endtask

  task automatic test_stall();
    load = 1'b1; in_d = 16'h0010; fetch_ready = 1'b0; inc_en = 1'b1;
    step();
    checks++;
    if (out_q !== 16'h0010 || flush !== 1'b1) begin
      $display("FAIL stall_setup: out=%h flush=%b required out=0010 flush=1", out_q, flush);
      failures++;
    end
    load = 1'b0; in_d = 16'hxxxx;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_q !== 16'h0010 || fetch_valid !== 1'b1 || flush !== 1'b0) begin
        $display("FAIL stall_hold[%0d]: out=%h valid=%b flush=%b required out=0010 valid=1 flush=0",
                 i, out_q, fetch_valid, flush);
        failures++;
      end
    end
    fetch_ready = 1'b1;
    step();
    checks++;
    if (out_q !== 16'h0011) begin
      $display("FAIL stall_release: out=%h required 0011", out_q);
      failures++;
    end
  endtask

  task automatic test_refetch();
    inc_en = 1'b0; fetch_ready = 1'b1;
    step();
    step();
    checks++;
    if (out_q !== 16'h0011 || flush !== 1'b0) begin
      $display("FAIL refetch_hold: out=%h flush=%b required out=0011 flush=0", out_q, flush);
      failures++;
    end
    inc_en = 1'b1;
  endtask

  task automatic test_jump();
    load = 1'b1; in_d = 16'h1234; fetch_ready = 1'b1; inc_en = 1'b1;
    step();
    checks++;
    if (out_q !== 16'h1234 || flush !== 1'b1) begin
      $display("FAIL jump_target: out=%h flush=%b required out=1234 flush=1", out_q, flush);
      failures++;
    end
    load = 1'b0; in_d = 16'hxxxx;
    step();
    checks++;
    if (out_q !== 16'h1235 || flush !== 1'b0) begin
      $display("FAIL jump_follow: out=%h flush=%b required out=1235 flush=0", out_q, flush);
      failures++;
    end
  endtask

  task automatic test_priority();
    load = 1'b1; in_d = 16'h0500; fetch_ready = 1'b0;
    step();
    checks++;
    if (out_q !== 16'h0500) begin
      $display("FAIL prio_setup: out=%h required 0500", out_q);
      failures++;
    end
    clr = 1'b1; load = 1'b1; in_d = 16'h00FF; fetch_ready = 1'b1;
    step();
    checks++;
    if (out_q !== 16'h0000 || flush !== 1'b1) begin
      $display("FAIL clr_over_load: out=%h flush=%b required out=0000 flush=1", out_q, flush);
      failures++;
    end
    clr = 1'b0; load = 1'b0; fetch_ready = 1'b0;
    step();
    checks++;
    if (out_q !== 16'h0000 || flush !== 1'b0) begin
      $display("FAIL prio_after: out=%h flush=%b required out=0000 flush=0", out_q, flush);
      failures++;
    end
  endtask

  task automatic test_wrap();
    load = 1'b1; in_d = 16'hFFFF; fetch_ready = 1'b0;
    step();
    checks++;
    if (out_q !== 16'hFFFF) begin
      $display("FAIL wrap_setup: out=%h required ffff", out_q);
      failures++;
    end
    load = 1'b0; fetch_ready = 1'b1; inc_en = 1'b1;
    step();
    checks++;
    if (out_q !== 16'h0000 || fetch_valid !== 1'b1 || flush !== 1'b0) begin
      $display("FAIL wrap_rollover: out=%h valid=%b flush=%b required out=0000 valid=1 flush=0",
               out_q, fetch_valid, flush);
      failures++;
    end
`ifdef PC_WRAP_FLAG_EN
    checks++;
    if (wrapped !== 1'b1) begin
      $display("FAIL wrap_flag_set: wrapped=%b required 1", wrapped);
      failures++;
    end
`endif
    load = 1'b1; in_d = 16'h0040; fetch_ready = 1'b0;
    step();
    checks++;
    if (out_q !== 16'h0040) begin
      $display("FAIL wrap_load: out=%h required 0040", out_q);
      failures++;
    end
`ifdef PC_WRAP_FLAG_EN
    checks++;
    if (wrapped !== 1'b1) begin
      $display("FAIL wrap_flag_load: wrapped=%b required 1", wrapped);
      failures++;
    end
`endif
    load = 1'b0; clr = 1'b1;
    step();
    checks++;
    if (out_q !== 16'h0000 || flush !== 1'b1) begin
      $display("FAIL wrap_clr: out=%h flush=%b required out=0000 flush=1", out_q, flush);
      failures++;
    end
`ifdef PC_WRAP_FLAG_EN
    checks++;
    if (wrapped !== 1'b0) begin
      $display("FAIL wrap_flag_clr: wrapped=%b required 0", wrapped);
      failures++;
    end
`endif
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    load = 1'b1; in_d = 16'h2222; fetch_ready = 1'b0;
    step();
    load = 1'b0;
    step();
    checks++;
    if (out_q !== 16'h2222 || fetch_valid !== 1'b1) begin
      $display("FAIL areset_setup: out=%h valid=%b required out=2222 valid=1", out_q, fetch_valid);
      failures++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_q !== 16'h0000 || fetch_valid !== 1'b0 || flush !== 1'b0) begin
      $display("FAIL areset_immediate: out=%h valid=%b flush=%b required out=0000 valid=0 flush=0",
               out_q, fetch_valid, flush);
      failures++;
    end
    #1 rst_n = 1'b1;
    // Redirect while still in BOOT
    load = 1'b1; in_d = 16'h0ABC;
    #1;
    checks++;
    if (fetch_valid !== 1'b0) begin
      $display("FAIL boot_no_valid: valid=%b required 0", fetch_valid);
      failures++;
    end
    step();
    checks++;
    if (out_q !== 16'h0ABC || flush !== 1'b1 || fetch_valid !== 1'b1) begin
      $display("FAIL boot_redirect: out=%h flush=%b valid=%b required out=0abc flush=1 valid=1",
               out_q, flush, fetch_valid);
      failures++;
    end
    load = 1'b0; fetch_ready = 1'b1;
    step();
    checks++;
    if (out_q !== 16'h0ABD || flush !== 1'b0) begin
      $display("FAIL boot_redirect_follow: out=%h flush=%b required out=0abd flush=0", out_q, flush);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_refetch();
    test_jump();
    test_priority();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
